// File: rtl/ait_arbiter.sv
// Three-requester round-robin arbiter for the AIT. It issues one operation at a time,
// waits the fixed AIT latency and returns the registered result to the granted requester.
module ait_arbiter #(
    parameter int literals = 8,
    parameter int clauses  = 16,
    parameter int OP_LAT   = 2,
    parameter int LOCK_MAX = 4,
    localparam int LW = $clog2(literals) + 1,
    localparam int DW = $clog2(literals),
    localparam int CW = $clog2(clauses)
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic [2:0]      Req_valid,
    input  logic [5:0]      Req_opCode,
    input  logic [3*LW-1:0] Req_LID,
    input  logic [2:0]      Req_lock,
    output logic [2:0]      Req_ready,
    output logic [2:0]      Rsp_valid,
    output logic            Rsp_Seen,
    output logic [DW-1:0]   Rsp_Declevel,
    output logic [CW-1:0]   Rsp_Reason,
    output logic [LW-1:0]   Rsp_LID,
    output logic            AIT_enable,
    output logic [1:0]      AIT_opCode,
    output logic [LW-1:0]   AIT_LID,
    input  logic            AIT_Seen,
    input  logic [DW-1:0]   AIT_Declevel,
    input  logic [CW-1:0]   AIT_Reason,
    input  logic [LW-1:0]   AIT_LID_in,
    output logic            Busy
);

    localparam int LKW = $clog2(LOCK_MAX) + 1;
    localparam logic [LKW-1:0] LOCK_LAST = LKW'(LOCK_MAX - 1);
    localparam logic [3:0]     LAT       = 4'(OP_LAT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t         state;
    logic [1:0]     ptr;
    logic [1:0]     win;
    logic [LKW-1:0] lock_cnt;
    logic [3:0]     wait_cnt;

    logic [1:0]     pick;
    logic [1:0]     pick_op;
    logic [1:0]     win_op;
    logic [LW-1:0]  pick_lid;
    logic [LW-1:0]  win_lid;
    logic           relock;

    // First requester with valid set, scanning upward from the one after p (wraps 2 -> 0).
    function automatic logic [1:0] rr_pick(input logic [1:0] p, input logic [2:0] v);
        logic [1:0] c;
        logic       found;
        rr_pick = p;
        c       = p;
        found   = 1'b0;
        for (int k = 0; k < 3; k++) begin
            c = (c >= 2'd2) ? 2'd0 : c + 2'd1;
            if (!found && v[c]) begin
                rr_pick = c;
                found   = 1'b1;
            end
        end
    endfunction

    always_comb begin
        pick     = rr_pick(ptr, Req_valid);
        pick_op  = Req_opCode[2*pick +: 2];
        pick_lid = Req_LID[LW*pick +: LW];
        win_op   = Req_opCode[2*win +: 2];
        win_lid  = Req_LID[LW*win +: LW];
        relock   = Req_lock[win] && Req_valid[win] && (lock_cnt < LOCK_LAST);
    end

    assign Busy = (state != IDLE);

    // The AIT_opCode/AIT_LID registers double as the latched request and hold between issues.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state        <= IDLE;
            ptr          <= 2'd2;
            win          <= 2'd0;
            lock_cnt     <= '0;
            wait_cnt     <= 4'd0;
            Req_ready    <= 3'b000;
            Rsp_valid    <= 3'b000;
            Rsp_Seen     <= 1'b0;
            Rsp_Declevel <= '0;
            Rsp_Reason   <= '0;
            Rsp_LID      <= '0;
            AIT_enable   <= 1'b0;
            AIT_opCode   <= 2'b00;
            AIT_LID      <= '0;
        end else begin
            AIT_enable <= 1'b0;
            Req_ready  <= 3'b000;
            Rsp_valid  <= 3'b000;
            case (state)
                IDLE: begin
                    if (|Req_valid) begin
                        win        <= pick;
                        ptr        <= pick;
                        AIT_opCode <= pick_op;
                        AIT_LID    <= pick_lid;
                        AIT_enable <= 1'b1;
                        Req_ready  <= 3'b001 << pick;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    wait_cnt <= 4'd1;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (wait_cnt == LAT) begin
                        Rsp_Seen     <= AIT_Seen;
                        Rsp_Declevel <= AIT_Declevel;
                        Rsp_Reason   <= AIT_Reason;
                        Rsp_LID      <= AIT_LID_in;
                        Rsp_valid    <= 3'b001 << win;
                        wait_cnt     <= 4'd0;
                        state        <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                RESP: begin
                    if (relock) begin
                        lock_cnt   <= lock_cnt + 1'b1;
                        AIT_opCode <= win_op;
                        AIT_LID    <= win_lid;
                        AIT_enable <= 1'b1;
                        Req_ready  <= 3'b001 << win;
                        state      <= ISSUE;
                    end else begin
                        lock_cnt <= '0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ait_arbiter.sv
// Bench for ait_arbiter: directed scenarios with literal expectations plus a long random run
// compared every cycle against a timeline-based reference model.
module tb_ait_arbiter;

    localparam int LIT = 8;
    localparam int CLS = 16;
    localparam int OPL = 2;
    localparam int LKM = 4;
    localparam int LW  = $clog2(LIT) + 1;
    localparam int DW  = $clog2(LIT);
    localparam int CW  = $clog2(CLS);

    logic            Clk;
    logic            Reset;
    logic [2:0]      Req_valid;
    logic [5:0]      Req_opCode;
    logic [3*LW-1:0] Req_LID;
    logic [2:0]      Req_lock;
    logic [2:0]      Req_ready;
    logic [2:0]      Rsp_valid;
    logic            Rsp_Seen;
    logic [DW-1:0]   Rsp_Declevel;
    logic [CW-1:0]   Rsp_Reason;
    logic [LW-1:0]   Rsp_LID;
    logic            AIT_enable;
    logic [1:0]      AIT_opCode;
    logic [LW-1:0]   AIT_LID;
    logic            AIT_Seen;
    logic [DW-1:0]   AIT_Declevel;
    logic [CW-1:0]   AIT_Reason;
    logic [LW-1:0]   AIT_LID_in;
    logic            Busy;

    ait_arbiter #(.literals(LIT), .clauses(CLS), .OP_LAT(OPL), .LOCK_MAX(LKM)) dut (
        .Clk(Clk), .Reset(Reset),
        .Req_valid(Req_valid), .Req_opCode(Req_opCode), .Req_LID(Req_LID), .Req_lock(Req_lock),
        .Req_ready(Req_ready), .Rsp_valid(Rsp_valid),
        .Rsp_Seen(Rsp_Seen), .Rsp_Declevel(Rsp_Declevel), .Rsp_Reason(Rsp_Reason), .Rsp_LID(Rsp_LID),
        .AIT_enable(AIT_enable), .AIT_opCode(AIT_opCode), .AIT_LID(AIT_LID),
        .AIT_Seen(AIT_Seen), .AIT_Declevel(AIT_Declevel), .AIT_Reason(AIT_Reason),
        .AIT_LID_in(AIT_LID_in), .Busy(Busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit ait_manual = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an operation is tracked by its age in cycles since its grant.
    // age 0 is the issue cycle, the AIT result is taken at age OPL, the response shows at OPL+1.
    bit              m_init = 1'b0;
    int              m_age, m_ptr, m_win, m_lock;
    logic [2:0]      e_ready, e_rspv;
    logic            e_en, e_seen;
    logic [1:0]      e_op;
    logic [LW-1:0]   e_lid, e_rlid;
    logic [DW-1:0]   e_dec;
    logic [CW-1:0]   e_rsn;

    function automatic void model_grant();
        m_age   = 0;
        e_en    = 1'b1;
        e_ready = 3'(1 << m_win);
        e_op    = 2'((Req_opCode >> (2 * m_win)) & 6'h3);
        e_lid   = LW'(Req_LID >> (LW * m_win));
    endfunction

    function automatic void model_step();
        bit found;
        e_ready = 3'b000;
        e_rspv  = 3'b000;
        e_en    = 1'b0;
        if (!Reset) begin
            m_init = 1'b1;
            m_age  = -1;
            m_ptr  = 2;
            m_win  = 0;
            m_lock = 0;
            e_op   = '0; e_lid = '0; e_seen = 1'b0; e_dec = '0; e_rsn = '0; e_rlid = '0;
        end else if (m_init) begin
            if (m_age < 0) begin
                if (Req_valid != 3'b000) begin
                    found = 1'b0;
                    for (int k = 1; k <= 3; k++) begin
                        if (!found && Req_valid[(m_ptr + k) % 3]) begin
                            m_win = (m_ptr + k) % 3;
                            found = 1'b1;
                        end
                    end
                    m_ptr = m_win;
                    model_grant();
                end
            end else if (m_age <= OPL) begin
                if (m_age == OPL) begin
                    e_seen = AIT_Seen; e_dec = AIT_Declevel; e_rsn = AIT_Reason; e_rlid = AIT_LID_in;
                    e_rspv = 3'(1 << m_win);
                end
                m_age++;
            end else begin
                if (Req_lock[m_win] && Req_valid[m_win] && m_lock < LKM - 1) begin
                    m_lock++;
                    model_grant();
                end else begin
                    m_lock = 0;
                    m_age  = -1;
                end
            end
        end
    endfunction

    always @(posedge Clk) begin
        model_step();
        #1;
        if (m_init) begin
            chk("m_ready",    32'(Req_ready),    32'(e_ready));
            chk("m_rspvalid", 32'(Rsp_valid),    32'(e_rspv));
            chk("m_enable",   32'(AIT_enable),   32'(e_en));
            chk("m_opcode",   32'(AIT_opCode),   32'(e_op));
            chk("m_ait_lid",  32'(AIT_LID),      32'(e_lid));
            chk("m_seen",     32'(Rsp_Seen),     32'(e_seen));
            chk("m_declevel", 32'(Rsp_Declevel), 32'(e_dec));
            chk("m_reason",   32'(Rsp_Reason),   32'(e_rsn));
            chk("m_rsp_lid",  32'(Rsp_LID),      32'(e_rlid));
            chk("m_busy",     32'(Busy),         32'(m_age >= 0));
            chk("m_excl",     32'((|Req_ready) && (|Rsp_valid)), 32'(0));
        end
    end

    always @(negedge Clk) begin
        AIT_Seen     = 1'($urandom);
        AIT_Declevel = DW'($urandom);
        AIT_Reason   = CW'($urandom);
        if (!ait_manual) AIT_LID_in = LW'($urandom);
    end

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b0;
        Req_valid = 3'b000; Req_lock = 3'b000; Req_opCode = '0; Req_LID = '0;
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
    endtask

    task automatic wait_grant(output int idx);
        idx = -1;
        for (int c = 0; c < 40 && idx < 0; c++) begin
            @(posedge Clk);
            #1;
            if (Req_ready != 3'b000) idx = Req_ready[1] ? 1 : (Req_ready[2] ? 2 : 0);
        end
        n_checks++;
        if (idx < 0) begin
            n_fail++;
            $display("FAIL grant_timeout: got no Req_ready in 40 cycles, required a grant");
        end else if (!$onehot(Req_ready)) begin
            n_fail++;
            $display("FAIL grant_onehot: got %b required one-hot", Req_ready);
        end
    endtask

    int g;
    int exp_rr[4]   = '{0, 1, 2, 0};
    int exp_lock[6] = '{0, 1, 1, 1, 1, 2};
    logic [LW-1:0] t1_vals[5];
    bit got_rsp;

    initial begin
        Reset = 1'b0;
        Req_valid = 3'b000; Req_lock = 3'b000; Req_opCode = '0; Req_LID = '0;
        AIT_LID_in = '0;
        repeat (3) @(negedge Clk);
        @(posedge Clk); #1;
        chk("rst_busy",    32'(Busy),       0);
        chk("rst_ready",   32'(Req_ready),  0);
        chk("rst_rspv",    32'(Rsp_valid),  0);
        chk("rst_enable",  32'(AIT_enable), 0);
        chk("rst_rsp_lid", 32'(Rsp_LID),    0);
        chk("rst_ait_lid", 32'(AIT_LID),    0);

        // Single request from requester 0, opcode 01, LID 5; AIT LID result steered by hand
        @(negedge Clk);
        Reset = 1'b1;
        ait_manual = 1'b1;
        AIT_LID_in = '0;
        Req_valid = 3'b001; Req_opCode = 6'b000001; Req_LID = 12'h005;
        @(posedge Clk); #1;
        chk("t1_ready",  32'(Req_ready),  32'b001);
        chk("t1_enable", 32'(AIT_enable), 1);
        chk("t1_lid",    32'(AIT_LID),    5);
        chk("t1_op",     32'(AIT_opCode), 1);
        t1_vals[2] = 4'd1; t1_vals[3] = 4'd2; t1_vals[4] = 4'd6;
        for (int k = 2; k <= 4; k++) begin
            @(negedge Clk);
            Req_valid = 3'b000;
            AIT_LID_in = t1_vals[k];
            @(posedge Clk); #1;
            chk("t1_enable_low", 32'(AIT_enable), 0);
            chk("t1_rspv", 32'(Rsp_valid), (k == 4) ? 32'b001 : 32'b000);
        end
        chk("t1_rsp_lid", 32'(Rsp_LID), 6);
        @(posedge Clk); #1;
        chk("t1_idle", 32'(Busy), 0);
        chk("t1_lid_hold", 32'(AIT_LID), 5);
        ait_manual = 1'b0;

        // All three requesting, no lock
        do_reset();
        Req_valid = 3'b111;
        for (int i = 0; i < 4; i++) begin
            wait_grant(g);
            chk("rr_order", 32'(g), 32'(exp_rr[i]));
        end

        // Requester 1 locking with everyone requesting
        do_reset();
        Req_valid = 3'b111; Req_lock = 3'b010;
        for (int i = 0; i < 6; i++) begin
            wait_grant(g);
            chk("lock_order", 32'(g), 32'(exp_lock[i]));
        end

        // Request fields change after the grant; response still delivered
        do_reset();
        Req_valid = 3'b010; Req_opCode = 6'b001100; Req_LID = 12'h050;
        wait_grant(g);
        chk("stab_grant", 32'(g), 1);
        chk("stab_lid0", 32'(AIT_LID), 5);
        @(negedge Clk);
        Req_LID = 12'h070; Req_valid = 3'b000;
        got_rsp = 1'b0;
        for (int c = 0; c < 10 && !got_rsp; c++) begin
            @(posedge Clk); #1;
            chk("stab_lid", 32'(AIT_LID), 5);
            if (Rsp_valid != 3'b000) begin
                got_rsp = 1'b1;
                chk("stab_rspv", 32'(Rsp_valid), 32'b010);
            end
        end
        chk("stab_rsp_seen", 32'(got_rsp), 1);

        // Reset while waiting on the AIT
        do_reset();
        Req_valid = 3'b010;
        wait_grant(g);
        @(posedge Clk); #1;
        chk("rw_busy_wait", 32'(Busy), 1);
        @(negedge Clk);
        Reset = 1'b0; Req_valid = 3'b111;
        @(posedge Clk); #1;
        chk("rw_busy", 32'(Busy), 0);
        chk("rw_rspv", 32'(Rsp_valid), 0);
        @(negedge Clk);
        Reset = 1'b1;
        wait_grant(g);
        chk("rw_grant", 32'(g), 0);

        // Random traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            @(negedge Clk);
            Reset      = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
            Req_valid  = 3'($urandom);
            Req_lock   = ($urandom_range(0, 3) != 0) ? 3'($urandom) : 3'b000;
            Req_opCode = 6'($urandom);
            Req_LID    = 12'($urandom);
        end
        @(negedge Clk);
        Reset = 1'b1;
        repeat (2) @(negedge Clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
